// File: rtl/adc128s022_responder.sv
// ADC128S022 SPI responder: serves locally written 12-bit channel samples with
// ADC128S022 framing (4 leading zeros, address on DIN bits 3..5, continuous mode).
module adc128s022_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int RESET_CH    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  input  logic        adc_saddr,
  output logic        adc_sdat,
  output logic        adc_sdat_oe,
  input  logic        ch_wr_en,
  input  logic [2:0]  ch_wr_addr,
  input  logic [11:0] ch_wr_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  last_addr
);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, saddr_sync;
  logic                   cs_d, sclk_d, saddr_d;
  logic                   cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [11:0] ch [8];

  state_t      state, state_n;
  logic [15:0] shift, shift_n;
  logic [4:0]  rise_cnt, rise_cnt_n;
  logic [2:0]  addr_sh, addr_sh_n;
  logic [2:0]  next_ch, next_ch_n;
  logic [2:0]  last_addr_n;
  logic        sdat_n, oe_n, done_n, err_n;

  // cs_n syncs to 1 so a reset never looks like a chip-select fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync    <= '1;
      sclk_sync  <= '0;
      saddr_sync <= '0;
      cs_d       <= 1'b1;
      sclk_d     <= 1'b0;
      saddr_d    <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
      saddr_sync <= {saddr_sync[SYNC_STAGES-2:0], adc_saddr};
      cs_d       <= cs_sync[SYNC_STAGES-1];
      sclk_d     <= sclk_sync[SYNC_STAGES-1];
      saddr_d    <= saddr_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) ch[i] <= '0;
    end else if (ch_wr_en) begin
      ch[ch_wr_addr] <= ch_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift       <= '0;
      rise_cnt    <= '0;
      addr_sh     <= '0;
      next_ch     <= 3'(RESET_CH);
      last_addr   <= '0;
      adc_sdat    <= 1'b0;
      adc_sdat_oe <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      shift       <= shift_n;
      rise_cnt    <= rise_cnt_n;
      addr_sh     <= addr_sh_n;
      next_ch     <= next_ch_n;
      last_addr   <= last_addr_n;
      adc_sdat    <= sdat_n;
      adc_sdat_oe <= oe_n;
      frame_done  <= done_n;
      frame_err   <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift;
    rise_cnt_n  = rise_cnt;
    addr_sh_n   = addr_sh;
    next_ch_n   = next_ch;
    last_addr_n = last_addr;
    sdat_n      = adc_sdat;
    oe_n        = adc_sdat_oe;
    done_n      = 1'b0;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        sdat_n = 1'b0;
        oe_n   = 1'b0;
        if (cs_fall) begin
          shift_n    = {4'b0, ch[next_ch]};
          rise_cnt_n = '0;
          sdat_n     = shift_n[15];
          oe_n       = 1'b1;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        // CS rise takes priority over any SCLK edge seen in the same cycle
        if (cs_rise) begin
          state_n = IDLE;
          oe_n    = 1'b0;
          sdat_n  = 1'b0;
          if (rise_cnt != 5'd0 && rise_cnt != 5'd16) err_n = 1'b1;
        end else if (sclk_rise && rise_cnt < 5'd16) begin
          rise_cnt_n = rise_cnt + 5'd1;
          if (rise_cnt_n >= 5'd3 && rise_cnt_n <= 5'd5) addr_sh_n = {addr_sh[1:0], saddr_d};
          if (rise_cnt_n == 5'd16) begin
            done_n      = 1'b1;
            next_ch_n   = addr_sh;
            last_addr_n = addr_sh;
          end
        end else if (sclk_fall) begin
          if (rise_cnt < 5'd16) begin
            shift_n = {shift[14:0], 1'b0};
            sdat_n  = shift[14];
          end else begin
            shift_n    = {4'b0, ch[next_ch]};
            sdat_n     = shift_n[15];
            rise_cnt_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc128s022_responder.sv
// Randomized bench for adc128s022_responder: an SPI initiator drives frames and
// compares received words and status pulses against a channel-table model.
module tb_adc128s022_responder;

  localparam int SYNC = 2;
  localparam int RCH  = 0;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        adc_cs_n = 1'b1;
  logic        adc_sclk = 1'b0;
  logic        adc_saddr = 1'b0;
  logic        adc_sdat, adc_sdat_oe;
  logic        ch_wr_en = 1'b0;
  logic [2:0]  ch_wr_addr = '0;
  logic [11:0] ch_wr_data = '0;
  logic        frame_done, frame_err;
  logic [2:0]  last_addr;

  adc128s022_responder #(.SYNC_STAGES(SYNC), .RESET_CH(RCH)) dut (
    .clk(clk), .reset(reset),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_saddr(adc_saddr),
    .adc_sdat(adc_sdat), .adc_sdat_oe(adc_sdat_oe),
    .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .last_addr(last_addr)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [11:0] ch_m [8];
  logic [2:0]  next_ch_m;
  logic [2:0]  last_addr_m;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ch_m[i] = '0;
    next_ch_m   = 3'(RCH);
    last_addr_m = '0;
  endtask

  task automatic wr_ch(input logic [2:0] a, input logic [11:0] d);
    @(posedge clk); #1;
    ch_wr_en = 1'b1; ch_wr_addr = a; ch_wr_data = d;
    @(posedge clk); #1;
    ch_wr_en = 1'b0;
    ch_m[a] = d;
  endtask

  // one SCLK period: DIN set while low, DOUT sampled just before the rising edge
  task automatic clk_bit(input logic din, input bit abort, output logic s, output logic oe);
    adc_saddr = din;
    repeat (HALF) @(posedge clk);
    #1;
    s  = adc_sdat;
    oe = adc_sdat_oe;
    adc_sclk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    if (abort) begin
      adc_cs_n = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
    end
    adc_sclk = 1'b0;
  endtask

  // abort_at: 0 = normal end, 1..16 = CS rises right after that rising edge (single word)
  task automatic run_frame(input int nwords, input logic [8:0] addrs, input int abort_at,
                           input bit wr_fall, input logic [2:0] wa, input logic [11:0] wd);
    int d0, e0, exp_done, exp_err, nw;
    logic [15:0] rx, expw;
    logic s, oe;
    logic [2:0] a;
    d0 = done_cnt; e0 = err_cnt;
    nw = (abort_at != 0) ? 1 : nwords;
    expw = {4'b0, ch_m[next_ch_m]};
    @(posedge clk); #1;
    adc_cs_n = 1'b0;
    if (wr_fall) begin
      repeat (SYNC) @(posedge clk);
      #1;
      ch_wr_en = 1'b1; ch_wr_addr = wa; ch_wr_data = wd;
      @(posedge clk); #1;
      ch_wr_en = 1'b0;
      ch_m[wa] = wd;
    end
    for (int w = 0; w < nw; w++) begin
      if (w != 0) expw = {4'b0, ch_m[next_ch_m]};
      a = addrs[3*w +: 3];
      rx = '0;
      for (int k = 1; k <= 16; k++) begin
        clk_bit((k >= 3 && k <= 5) ? a[5-k] : 1'($urandom), abort_at == k, s, oe);
        rx[16-k] = s;
        if (k == 1) check_val("oe_in_frame", 32'(oe), 32'd1);
        if (abort_at == k) break;
      end
      if (abort_at == 0 || abort_at == 16) begin
        check_val("dout_word", 32'(rx), 32'(expw));
        next_ch_m   = a;
        last_addr_m = a;
      end
    end
    if (abort_at == 0) begin
      repeat (HALF) @(posedge clk);
      #1;
      adc_cs_n = 1'b1;
    end
    exp_done = (abort_at == 0) ? nw : (abort_at == 16 ? 1 : 0);
    exp_err  = (abort_at != 0 && abort_at < 16) ? 1 : 0;
    repeat (HALF) @(posedge clk);
    #1;
    check_val("oe_after_cs", 32'(adc_sdat_oe), 32'd0);
    check_val("sdat_after_cs", 32'(adc_sdat), 32'd0);
    check_val("last_addr", 32'(last_addr), 32'(last_addr_m));
    check_val("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    check_val("err_pulses", 32'(err_cnt - e0), 32'(exp_err));
  endtask

  initial begin
    logic s, oe;
    model_reset();
    #1;
    check_val("rst_sdat", 32'(adc_sdat), 32'd0);
    check_val("rst_oe", 32'(adc_sdat_oe), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_err", 32'(frame_err), 32'd0);
    check_val("rst_last_addr", 32'(last_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);

    // directed frames
    wr_ch(3'd0, 12'hABC);
    run_frame(1, 9'(3), 0, 1'b0, '0, '0);
    wr_ch(3'd3, 12'h5A5);
    run_frame(1, 9'(7), 0, 1'b0, '0, '0);
    run_frame(1, 9'(0), 0, 1'b0, '0, '0);

    // continuous conversion, addresses 1,2,0
    wr_ch(3'd1, 12'h111);
    wr_ch(3'd2, 12'h222);
    run_frame(3, {3'd0, 3'd2, 3'd1}, 0, 1'b0, '0, '0);

    // abort after 7 rising edges, then the next frame still uses the old next_ch
    run_frame(1, 9'(5), 7, 1'b0, '0, '0);
    run_frame(1, 9'(4), 0, 1'b0, '0, '0);
    // CS rise right after the 16th rising edge completes without error
    run_frame(1, 9'(0), 16, 1'b0, '0, '0);

    // write to the converted channel in the load cycle: old value now, new value next
    run_frame(1, 9'(0), 0, 1'b1, 3'd0, 12'h3C6);
    run_frame(1, 9'(6), 0, 1'b0, '0, '0);

    // reset mid-frame at bit 9
    wr_ch(3'd6, 12'hFED);
    @(posedge clk); #1;
    adc_cs_n = 1'b0;
    for (int k = 1; k <= 9; k++) clk_bit(1'($urandom), 1'b0, s, oe);
    repeat (SYNC + 2) @(posedge clk);
    check_val("oe_before_rst", 32'(adc_sdat_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("midrst_sdat", 32'(adc_sdat), 32'd0);
    check_val("midrst_oe", 32'(adc_sdat_oe), 32'd0);
    check_val("midrst_last_addr", 32'(last_addr), 32'd0);
    adc_cs_n = 1'b1;
    adc_sclk = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    run_frame(1, 9'(2), 0, 1'b0, '0, '0);

    // randomized traffic
    for (int r = 0; r < 10; r++) begin
      int nwr, ab;
      nwr = $urandom_range(0, 3);
      for (int j = 0; j < nwr; j++) wr_ch(3'($urandom), 12'($urandom));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      run_frame($urandom_range(1, 3), 9'($urandom), ab,
                ($urandom_range(0, 4) == 0), 3'($urandom), 12'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
